// File: rtl/min_list_drainer.sv
// Captures one sorted min-list from the check-node sorter into a local buffer, then replays it
// in arrival order over a valid/ready handshake. Optional LLR ordering monitor: MIN_LIST_ORDER_CHECK_EN.
`timescale 1ns/1ps

module min_list_drainer #(
    parameter int N_m          = 31,
    parameter int LLR_Width    = 5,
    parameter int Q_Width      = 6,
    parameter int IndexA_Width = 5,
    parameter int IndexI_Width = 5
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [LLR_Width:0]    In_LLR,
    input  logic [Q_Width:0]      In_Q,
    input  logic [IndexA_Width:0] In_IndexA,
    input  logic [IndexI_Width:0] In_IndexI,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [LLR_Width:0]    Out_LLR,
    output logic [Q_Width:0]      Out_Q,
    output logic [IndexA_Width:0] Out_IndexA,
    output logic [IndexI_Width:0] Out_IndexI,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done,
    output logic                  order_err
);

    localparam int              PTR_W    = (N_m < 1) ? 1 : $clog2(N_m + 1);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(N_m);

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        DRAIN
    } state_t;

    typedef struct packed {
        logic [LLR_Width:0]    llr;
        logic [Q_Width:0]      q;
        logic [IndexA_Width:0] index_a;
        logic [IndexI_Width:0] index_i;
    } entry_t;

    state_t           state;
    state_t           state_next;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] rd_next;
    entry_t           list_mem [0:N_m];
    entry_t           in_entry;
    entry_t           out_entry;
    logic             wr_en;
    logic             load_first;
    logic             advance;
    logic             finish;
    logic             start_accepted;

    assign in_entry       = '{llr: In_LLR, q: In_Q, index_a: In_IndexA, index_i: In_IndexI};
    assign rd_next        = rd_ptr + 1'b1;
    assign start_accepted = (state == IDLE) && start;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        wr_en      = 1'b0;
        load_first = 1'b0;
        advance    = 1'b0;
        finish     = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_next = CAPTURE;
                end
            end
            CAPTURE: begin
                if (in_valid) begin
                    wr_en = 1'b1;
                    if (wr_ptr == LAST_IDX) begin
                        state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // out_valid is low in DRAIN only on the first cycle, before entry 0 is presented.
                if (!out_valid) begin
                    load_first = 1'b1;
                end else if (out_ready) begin
                    if (rd_ptr == LAST_IDX) begin
                        finish     = 1'b1;
                        state_next = IDLE;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            out_valid <= 1'b0;
            done      <= 1'b0;
            out_entry <= '0;
        end else begin
            done <= finish;
            if (start_accepted) begin
                wr_ptr <= '0;
            end else if (wr_en && (wr_ptr != LAST_IDX)) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (load_first) begin
                rd_ptr    <= '0;
                out_entry <= list_mem[0];
                out_valid <= 1'b1;
            end else if (advance) begin
                rd_ptr    <= rd_next;
                out_entry <= list_mem[rd_next];
            end else if (finish) begin
                out_valid <= 1'b0;
            end
        end
    end

    // NOTE: the list buffer has no reset; every entry is written before it can be read.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            list_mem[wr_ptr] <= in_entry;
        end
    end

    assign Out_LLR    = out_entry.llr;
    assign Out_Q      = out_entry.q;
    assign Out_IndexA = out_entry.index_a;
    assign Out_IndexI = out_entry.index_i;
    assign out_last   = out_valid && (rd_ptr == LAST_IDX);
    assign busy       = (state != IDLE);

`ifdef MIN_LIST_ORDER_CHECK_EN
    logic [LLR_Width:0] prev_llr;
    logic               order_err_q;

    // The first entry of a list has no predecessor, so it is never compared.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_llr    <= '0;
            order_err_q <= 1'b0;
        end else begin
            if (start_accepted) begin
                order_err_q <= 1'b0;
            end else if (wr_en && (wr_ptr != '0) && (In_LLR < prev_llr)) begin
                order_err_q <= 1'b1;
            end
            if (wr_en) begin
                prev_llr <= In_LLR;
            end
        end
    end

    assign order_err = order_err_q;
`else
    assign order_err = 1'b0;
`endif

endmodule

// File: tb/tb_min_list_drainer.sv
// Scoreboard bench for min_list_drainer: the driver queues expected entries as it writes them,
// an independent negedge monitor compares and pops them as the DUT hands them out.
`timescale 1ns/1ps

module tb_min_list_drainer;

    localparam int N_m = 31;
`ifdef MIN_LIST_ORDER_CHECK_EN
    localparam bit ORDER_EN = 1'b1;
`else
    localparam bit ORDER_EN = 1'b0;
`endif

    typedef struct {
        logic [5:0] llr;
        logic [6:0] q;
        logic [5:0] ia;
        logic [5:0] ii;
        bit         last;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic       in_valid = 1'b0;
    logic [5:0] in_llr = '0;
    logic [6:0] in_q = '0;
    logic [5:0] in_ia = '0;
    logic [5:0] in_ii = '0;
    logic       out_ready = 1'b0;
    logic       out_valid;
    logic [5:0] out_llr;
    logic [6:0] out_q;
    logic [5:0] out_ia;
    logic [5:0] out_ii;
    logic       out_last;
    logic       busy;
    logic       done;
    logic       order_err;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t exp_q[$];
    bit   exp_done = 1'b0;
    bit   ready_toggle = 1'b0;

    min_list_drainer dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .in_valid   (in_valid),
        .In_LLR     (in_llr),
        .In_Q       (in_q),
        .In_IndexA  (in_ia),
        .In_IndexI  (in_ii),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .Out_LLR    (out_llr),
        .Out_Q      (out_q),
        .Out_IndexA (out_ia),
        .Out_IndexI (out_ii),
        .out_last   (out_last),
        .busy       (busy),
        .done       (done),
        .order_err  (order_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t gen_entry(input int kind, input int i);
        exp_t e;
        e.llr  = 6'(i);
        e.q    = 7'(i * 3);
        e.ia   = 6'(i);
        e.ii   = 6'(63 - i);
        e.last = (i == N_m);
        if (kind == 1) begin
            e.q  = 7'd7;
            e.ii = 6'(31 - i);
        end else if (kind == 2 && i == 3) begin
            e.llr = 6'd1;
        end
        return e;
    endfunction

    task automatic do_start();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // kind 2 carries one descending step at write 3; order_err must follow only when built in.
    task automatic send_list(input int kind, input int gap, input int count, input bit push);
        exp_t e;
        for (int i = 0; i < count; i++) begin
            repeat (gap) begin
                in_valid = 1'b0;
                tick();
            end
            e        = gen_entry(kind, i);
            in_valid = 1'b1;
            in_llr   = e.llr;
            in_q     = e.q;
            in_ia    = e.ia;
            in_ii    = e.ii;
            if (push) exp_q.push_back(e);
            tick();
            check("order_err", 64'(order_err), 64'(ORDER_EN && kind == 2 && i >= 3));
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_done();
        bit seen = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        check("done_seen", 64'(seen), 64'd1);
        check("busy_at_done", 64'(busy), 64'd0);
        check("all_delivered", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            out_ready = ready_toggle ? ~out_ready : 1'b1;
        end
    end

    // Monitor: Out_* must always show the head of the queue; a handshake pops it.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset_n) begin
                check("done_pulse", 64'(done), 64'(exp_done));
                exp_done = 1'b0;
                if (out_valid) begin
                    check("out_expected", 64'(exp_q.size() != 0), 64'd1);
                    if (exp_q.size() != 0) begin
                        e = exp_q[0];
                        check("out_llr", 64'(out_llr), 64'(e.llr));
                        check("out_q", 64'(out_q), 64'(e.q));
                        check("out_index_a", 64'(out_ia), 64'(e.ia));
                        check("out_index_i", 64'(out_ii), 64'(e.ii));
                        check("out_last", 64'(out_last), 64'(e.last));
                        if (out_ready) begin
                            void'(exp_q.pop_front());
                            exp_done = e.last;
                        end
                    end
                end else begin
                    check("out_last_idle", 64'(out_last), 64'd0);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_last", 64'(out_last), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_order_err", 64'(order_err), 64'd0);
        check("rst_out_data", 64'({out_llr, out_q, out_ia, out_ii}), 64'd0);
        reset_n = 1'b1;

        // 1: ascending LLR 0..31, ready held high, first output one clock after last write
        do_start();
        check("busy_capture", 64'(busy), 64'd1);
        send_list(0, 0, 32, 1'b1);
        check("lat_not_yet", 64'(out_valid), 64'd0);
        tick();
        check("lat_first_valid", 64'(out_valid), 64'd1);
        wait_done();

        // 2: ready toggling, each entry must be held across ready=0
        ready_toggle = 1'b1;
        do_start();
        send_list(0, 0, 32, 1'b1);
        wait_done();
        ready_toggle = 1'b0;

        // 3: in_valid every third clock, Q=7, IndexA=i, IndexI=31-i
        do_start();
        send_list(1, 2, 32, 1'b1);
        wait_done();

        // 4: junk writes before start and during drain; start held through the final handshake
        in_valid = 1'b1;
        in_llr   = 6'h3f;
        in_q     = 7'h7f;
        in_ia    = 6'h3f;
        in_ii    = 6'h3f;
        repeat (3) tick();
        check("idle_ignores_valid", 64'(busy), 64'd0);
        do_start();
        send_list(0, 0, 32, 1'b1);
        in_valid = 1'b1;
        in_llr   = 6'h3f;
        start    = 1'b1;
        wait_done();
        start    = 1'b0;
        in_valid = 1'b0;
        repeat (2) tick();
        check("start_dropped", 64'(busy), 64'd0);

        // 5: reset after 10 captured entries, then a full list
        do_start();
        send_list(0, 0, 10, 1'b0);
        reset_n = 1'b0;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_out_valid", 64'(out_valid), 64'd0);
        tick();
        reset_n = 1'b1;
        do_start();
        send_list(1, 0, 32, 1'b1);
        wait_done();

        // 6: 0,1,2,1,... ordering flag, sticky through drain, cleared by the next start
        do_start();
        send_list(2, 0, 32, 1'b1);
        wait_done();
        check("order_err_sticky", 64'(order_err), 64'(ORDER_EN));
        do_start();
        check("order_err_cleared", 64'(order_err), 64'd0);
        send_list(0, 0, 32, 1'b1);
        wait_done();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
